// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: MDU sequencer state encoding and MDU op codes.
// Used by muldiv_stall_ctrl (optional build macro there: MDU_STALL_CNT_EN).
package mips_ctrl_pkg;

    // MDU sequencer states; kept as plain 2-bit constants so legacy decode logic
    // that compares against literal values stays compatible.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] WB   = 2'd2;

    // MDU operation: bit 1 selects divide, bit 0 selects the signed variant.
    typedef enum logic [1:0] {
        MDU_OP_MULTU = 2'b00,
        MDU_OP_MULT  = 2'b01,
        MDU_OP_DIVU  = 2'b10,
        MDU_OP_DIV   = 2'b11
    } mdu_op_t;

    // Build the op code from the ID decode flags.
    function automatic mdu_op_t mdu_op_encode(input logic is_div, input logic is_signed);
        return mdu_op_t'({is_div, is_signed});
    endfunction

    function automatic logic mdu_op_is_div(input mdu_op_t op);
        return op[1];
    endfunction

    function automatic logic mdu_op_is_signed(input mdu_op_t op);
        return op[0];
    endfunction

endpackage

// File: rtl/mdu_iter_counter.sv
// MDU iteration counter: loads the step count minus one, decrements while
// stepping, and holds at zero so it can never wrap.
module mdu_iter_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins over decrement; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/muldiv_stall_ctrl.sv
// MDU sequencer and HI/LO stall control beside the load-use hazard logic.
// Issues MULT/MULTU/DIV/DIVU from ID, times the MDU iterations, pulses the
// HI/LO write and holds the front end while the MDU is busy.
// Build option: define MDU_STALL_CNT_EN to build the saturating stall-cycle
// performance counter; otherwise stall_cycles_o is tied to zero.
module muldiv_stall_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES  = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ID_mult_i,
    input  logic                   ID_div_i,
    input  logic                   ID_signed_i,
    input  logic                   ID_hilo_use_i,
    input  logic                   ID_flush_i,
    output logic                   mdu_start_o,
    output logic                   mdu_is_div_o,
    output logic                   mdu_signed_o,
    output logic                   mdu_step_o,
    output logic                   hilo_write_o,
    output logic                   pc_hold_o,
    output logic                   IF_ID_hold_o,
    output logic                   ID_EX_bubble_o,
    output logic                   busy_o,
    output logic [STALL_CNT_W-1:0] stall_cycles_o
);

    // Counter preload is N-1 so the RUN state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [1:0] state_q;
    logic [1:0] state_d;
    mdu_op_t    op_q;
    mdu_op_t    op_d;
    logic       id_muldiv;
    logic       issue;
    logic       stall;
    logic       cnt_zero;
    logic       cnt_dec;

    assign id_muldiv = ID_mult_i | ID_div_i;

    // A flushed ID op neither issues nor stalls; reset masks both so every
    // output is quiet while reset is held.
    assign issue = ~reset & id_muldiv & ~ID_flush_i & (state_q == IDLE);
    assign stall = ~reset & (state_q != IDLE) & (id_muldiv | ID_hilo_use_i) & ~ID_flush_i;

    // Divide wins if decode ever flags both (illegal) at once.
    assign op_d    = issue ? mdu_op_encode(ID_div_i, ID_signed_i) : op_q;
    assign cnt_dec = (state_q == RUN);

    mdu_iter_counter #(
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (issue),
        .load_val_i (ID_div_i ? DIV_LOAD : MUL_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // FSM next state: IDLE -> RUN on issue, RUN -> WB when the count hits zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = RUN;
            RUN:     if (cnt_zero) state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and op latch; reset aborts any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= MDU_OP_MULTU;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    assign mdu_start_o    = issue;
    assign mdu_is_div_o   = mdu_op_is_div(op_q);
    assign mdu_signed_o   = mdu_op_is_signed(op_q);
    assign mdu_step_o     = ~reset & (state_q == RUN);
    assign hilo_write_o   = ~reset & (state_q == WB);
    assign busy_o         = ~reset & (state_q != IDLE);
    assign pc_hold_o      = stall;
    assign IF_ID_hold_o   = stall;
    assign ID_EX_bubble_o = stall;

`ifdef MDU_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Stall-cycle performance counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign stall_cycles_o = stall_cnt_q;
`else
    assign stall_cycles_o = '0;
`endif

endmodule
